// File: rtl/adder_rr_arbiter.sv
// One shared DATA_W-bit adder time-multiplexed among N_REQ requesters.
// Round-robin grant, registered operands, registered result with valid/ready.
module adder_rr_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ID_W   = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*DATA_W-1:0]   src1_i,
   input  logic [N_REQ*DATA_W-1:0]   src2_i,
   output logic [N_REQ-1:0]          gnt_o,
   output logic [DATA_W-1:0]         sum_o,
   output logic                      carry_o,
   output logic                      ovf_o,
   output logic [ID_W-1:0]           id_o,
   output logic                      valid_o,
   input  logic                      ready_i
);

   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic [ID_W-1:0]     cap_id_q, cap_id_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic                carry_q, carry_d;
   logic                ovf_q, ovf_d;
   logic [ID_W-1:0]     id_q, id_d;

   logic [N_REQ-1:0]    hi_req_c;
   logic                win_found_c;
   logic [ID_W-1:0]     win_id_c;
   logic [DATA_W-1:0]   win_op1_c;
   logic [DATA_W-1:0]   win_op2_c;
   logic [DATA_W:0]     add_full_c;
   logic                add_ovf_c;

   // Round-robin pick: lowest request at or above ptr, else lowest overall.
   always_comb begin
      hi_req_c    = '0;
      win_found_c = 1'b0;
      win_id_c    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         hi_req_c[i] = req_i[i] && (ID_W'(i) >= ptr_q);
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!win_found_c && hi_req_c[i]) begin
            win_id_c    = ID_W'(i);
            win_found_c = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!win_found_c && req_i[i]) begin
            win_id_c    = ID_W'(i);
            win_found_c = 1'b1;
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      win_op1_c = '0;
      win_op2_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == win_id_c) begin
            win_op1_c = src1_i[i*DATA_W +: DATA_W];
            win_op2_c = src2_i[i*DATA_W +: DATA_W];
         end
      end
   end

   // The shared adder, fed only from the operand registers.
   always_comb begin
      add_full_c = {1'b0, op1_q} + {1'b0, op2_q};
      add_ovf_c  = (op1_q[DATA_W-1] == op2_q[DATA_W-1]) &&
                   (add_full_c[DATA_W-1] != op1_q[DATA_W-1]);
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      cap_id_d = cap_id_q;
      gnt_d    = '0;
      valid_d  = valid_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      id_d     = id_q;
      case (state_q)
         IDLE: begin
            if (win_found_c) begin
               op1_d    = win_op1_c;
               op2_d    = win_op2_c;
               cap_id_d = win_id_c;
               gnt_d    = N_REQ'(1) << win_id_c;
               state_d  = CALC;
            end
         end
         CALC: begin
            sum_d   = add_full_c[DATA_W-1:0];
            carry_d = add_full_c[DATA_W];
            ovf_d   = add_ovf_c;
            id_d    = cap_id_q;
            valid_d = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (ready_i) begin
               valid_d = 1'b0;
               ptr_d   = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         cap_id_q <= '0;
         gnt_q    <= '0;
         valid_q  <= 1'b0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         cap_id_q <= cap_id_d;
         gnt_q    <= gnt_d;
         valid_q  <= valid_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         id_q     <= id_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign valid_o = valid_q;
   assign sum_o   = sum_q;
   assign carry_o = carry_q;
   assign ovf_o   = ovf_q;
   assign id_o    = id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: inputs driven and outputs checked on
// the falling edge, expected values written out by hand.
module tb_adder_rr_arbiter;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned ID_W   = 2;

   logic                    clk_i;
   logic                    rst_i;
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ*DATA_W-1:0] src1_i;
   logic [N_REQ*DATA_W-1:0] src2_i;
   logic [N_REQ-1:0]        gnt_o;
   logic [DATA_W-1:0]       sum_o;
   logic                    carry_o;
   logic                    ovf_o;
   logic [ID_W-1:0]         id_o;
   logic                    valid_o;
   logic                    ready_i;

   int n_checks;
   int n_fail;

   adder_rr_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .src1_i  (src1_i),
      .src2_i  (src2_i),
      .gnt_o   (gnt_o),
      .sum_o   (sum_o),
      .carry_o (carry_o),
      .ovf_o   (ovf_o),
      .id_o    (id_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic set_ops(input int k, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      src1_i[k*DATA_W +: DATA_W] = a;
      src2_i[k*DATA_W +: DATA_W] = b;
   endtask

   // One full request/grant/result/accept cycle with ready_i high.
   task automatic run_op(input string tag, input logic [N_REQ-1:0] req,
                         input logic [N_REQ-1:0] exp_gnt, input logic [ID_W-1:0] exp_id,
                         input logic [DATA_W-1:0] exp_sum, input logic exp_c, input logic exp_o);
      req_i = req;
      step();
      check({tag, ".gnt"}, 64'(gnt_o), 64'(exp_gnt));
      check({tag, ".valid_early"}, 64'(valid_o), 64'd0);
      req_i = '0;
      step();
      check({tag, ".valid"}, 64'(valid_o), 64'd1);
      check({tag, ".sum"}, 64'(sum_o), 64'(exp_sum));
      check({tag, ".carry"}, 64'(carry_o), 64'(exp_c));
      check({tag, ".ovf"}, 64'(ovf_o), 64'(exp_o));
      check({tag, ".id"}, 64'(id_o), 64'(exp_id));
      check({tag, ".gnt_off"}, 64'(gnt_o), 64'd0);
      step();
      check({tag, ".valid_drop"}, 64'(valid_o), 64'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      req_i = '0;
      step();
      check("rst.gnt", 64'(gnt_o), 64'd0);
      check("rst.valid", 64'(valid_o), 64'd0);
      check("rst.sum", 64'(sum_o), 64'd0);
      check("rst.carry", 64'(carry_o), 64'd0);
      check("rst.ovf", 64'(ovf_o), 64'd0);
      check("rst.id", 64'(id_o), 64'd0);
      rst_i = 1'b0;
   endtask

   logic [N_REQ-1:0]  rr_gnt [5];
   logic [ID_W-1:0]   rr_id  [5];
   logic [DATA_W-1:0] rr_sum [5];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_i    = 1'b1;
      req_i    = '0;
      ready_i  = 1'b1;
      src1_i   = '0;
      src2_i   = '0;
      @(negedge clk_i);
      do_reset();

      // Single request, ready tied high.
      set_ops(0, 32'd5, 32'd7);
      run_op("t1", 4'b0001, 4'b0001, 2'd0, 32'd12, 1'b0, 1'b0);

      // Round-robin with all four held; ptr back to 0 after reset.
      do_reset();
      set_ops(0, 32'd1,  32'd0);
      set_ops(1, 32'd17, 32'd1);
      set_ops(2, 32'd33, 32'd2);
      set_ops(3, 32'd49, 32'd3);
      rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_sum = '{32'd1, 32'd18, 32'd35, 32'd52, 32'd1};
      req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2.gnt", 64'(gnt_o), 64'(rr_gnt[i]));
         step();
         check("t2.valid", 64'(valid_o), 64'd1);
         check("t2.id", 64'(id_o), 64'(rr_id[i]));
         check("t2.sum", 64'(sum_o), 64'(rr_sum[i]));
         step();
         check("t2.valid_drop", 64'(valid_o), 64'd0);
         check("t2.gnt_gap", 64'(gnt_o), 64'd0);
      end
      req_i = '0;

      // Arithmetic edges on requester 2 (ptr=1 -> 2 wins).
      set_ops(2, 32'hFFFF_FFFF, 32'h1);
      run_op("t3a", 4'b0100, 4'b0100, 2'd2, 32'h0, 1'b1, 1'b0);
      set_ops(2, 32'h7FFF_FFFF, 32'h1);
      run_op("t3b", 4'b0100, 4'b0100, 2'd2, 32'h8000_0000, 1'b0, 1'b1);
      set_ops(2, 32'h8000_0000, 32'h8000_0000);
      run_op("t3c", 4'b0100, 4'b0100, 2'd2, 32'h0, 1'b1, 1'b1);

      // Wrap-around: last winner 3, then 1001 must go to 0.
      set_ops(3, 32'd10, 32'd20);
      run_op("t5a", 4'b1000, 4'b1000, 2'd3, 32'd30, 1'b0, 1'b0);
      set_ops(0, 32'd100, 32'd23);
      set_ops(3, 32'd1, 32'd1);
      run_op("t5b", 4'b1001, 4'b0001, 2'd0, 32'd123, 1'b0, 1'b0);

      // Backpressure with 0110 pending (ptr=1 here, requester 3 wins first).
      set_ops(3, 32'd1000, 32'd234);
      set_ops(1, 32'd3, 32'd4);
      set_ops(2, 32'd50, 32'd50);
      req_i = 4'b1000;
      step();
      check("t4.gnt", 64'(gnt_o), 64'b1000);
      req_i   = 4'b0110;
      ready_i = 1'b0;
      step();
      check("t4.valid", 64'(valid_o), 64'd1);
      check("t4.sum", 64'(sum_o), 64'd1234);
      check("t4.id", 64'(id_o), 64'd3);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4.hold_valid", 64'(valid_o), 64'd1);
         check("t4.hold_sum", 64'(sum_o), 64'd1234);
         check("t4.hold_id", 64'(id_o), 64'd3);
         check("t4.hold_gnt", 64'(gnt_o), 64'd0);
      end
      ready_i = 1'b1;
      step();
      check("t4.accept_valid", 64'(valid_o), 64'd0);
      check("t4.accept_gnt", 64'(gnt_o), 64'd0);
      step();
      check("t4.next_gnt", 64'(gnt_o), 64'b0010);
      req_i = '0;
      step();
      check("t4.next_valid", 64'(valid_o), 64'd1);
      check("t4.next_sum", 64'(sum_o), 64'd7);
      check("t4.next_id", 64'(id_o), 64'd1);
      step();
      check("t4.next_drop", 64'(valid_o), 64'd0);

      // Reset in CALC discards the operation; held request re-granted.
      set_ops(2, 32'h11, 32'h22);
      req_i = 4'b0100;
      step();
      check("t6.gnt", 64'(gnt_o), 64'b0100);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("t6.rst_valid", 64'(valid_o), 64'd0);
      check("t6.rst_gnt", 64'(gnt_o), 64'd0);
      check("t6.rst_sum", 64'(sum_o), 64'd0);
      check("t6.rst_id", 64'(id_o), 64'd0);
      step();
      check("t6.regnt", 64'(gnt_o), 64'b0100);
      check("t6.no_stale_valid", 64'(valid_o), 64'd0);
      req_i = '0;
      step();
      check("t6.valid", 64'(valid_o), 64'd1);
      check("t6.sum", 64'(sum_o), 64'h33);
      check("t6.id", 64'(id_o), 64'd2);
      step();
      check("t6.drop", 64'(valid_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one DATA_W-bit adder among N_REQ requesters, e.g. the PC+4 path, the branch-target path and the address-calc path.
- Arbitration is round-robin. Operands are registered on grant, the sum is computed from those registered operands, and the result is held in an output register with valid/ready backpressure.
- Sits between the fetch/decode-stage requesters and their result consumers. This removes duplicated adders in the multi-cycle datapath.

Parameters:
- DATA_W, 32, operand/sum width.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-index width; must be at least max(1, ceil(log2(N_REQ))).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset; sampled on the rising edge of clk_i.
- req_i  input  N_REQ  per-requester request; held high until that requester's gnt_o bit is seen.
- src1_i  input  N_REQ*DATA_W  packed first operands; requester k occupies bits [k*DATA_W +: DATA_W].
- src2_i  input  N_REQ*DATA_W  packed second operands, same packing as src1_i.
- gnt_o  output  N_REQ  one-hot, one-cycle pulse: operands of that requester have been captured.
- sum_o  output  DATA_W  src1+src2 of the granted request, modulo 2^DATA_W.
- carry_o  output  1  unsigned carry-out (bit DATA_W of the full sum).
- ovf_o  output  1  signed overflow: operand signs equal and sum sign differs.
- id_o  output  ID_W  index of the requester that owns sum_o.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result when valid_o and ready_i are both high at a rising edge.

Behaviour:
- Reset values: state=IDLE, ptr=0, gnt_o=0, valid_o=0, sum_o=0, carry_o=0, ovf_o=0, id_o=0, operand registers=0.
- Reset mid-operation: any captured operands or pending result are discarded. No valid_o is produced for them, and that requester must re-request.
- FSM states:
  - IDLE: if req_i==0, stay in IDLE. Otherwise pick the winner w: the first set bit of req_i searching ptr, ptr+1, … N_REQ-1, 0, … ptr-1. At the edge: latch src1/src2 of w into the operand registers, latch id=w, set gnt_o=onehot(w) for the next cycle only, go to CALC.
  - CALC: adder input = operand registers; req_i is not sampled. At the edge: sum_o, carry_o, ovf_o and id_o are registered, valid_o=1, gnt_o=0, go to HOLD.
  - HOLD: valid_o=1; sum_o, carry_o, ovf_o and id_o are stable. When ready_i=1 at the edge: valid_o=0, ptr=(id+1) mod N_REQ, go to IDLE. When ready_i=0: remain in HOLD.
- Latency and throughput:
  - req_i sampled high in IDLE at cycle 0 → gnt_o high in cycle 1 → valid_o high in cycle 2.
  - With ready_i tied high, valid_o lasts one cycle.
  - Maximum rate is one operation per 3 cycles.
- Requester rule: drop req_i in the cycle gnt_o is seen, or in the following cycle. A req_i still high when the FSM returns to IDLE is treated as a new request.
- Fairness: ptr advances only on result acceptance, to one past the last winner. Every continuously asserted request is granted within N_REQ operations.
- ptr wrap-around: N_REQ-1 → 0.
- Arithmetic: full DATA_W+1-bit add. sum_o = low DATA_W bits, carry_o = MSB. ovf_o = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- Boundary conditions:
  - A request withdrawn before being sampled in IDLE gets no grant.
  - Requests arriving during CALC or HOLD wait.
  - ready_i while valid_o=0 is ignored.
  - Simultaneous rst_i and ready_i: reset wins.
- Operand bits of non-granted requesters have no effect.

Test Plan:
1. Single request, ready tied high: req_i=0001, src1=5, src2=7 → gnt_o=0001 in cycle 1; valid_o=1, sum_o=12, id_o=0, carry_o=0, ovf_o=0 in cycle 2; valid_o=0 in cycle 3.
2. Round-robin: req_i=1111 held (each requester re-requests after its grant), ready high → grant order 0,1,2,3,0; gnt_o pulses every 3 cycles; id_o follows the same sequence.
3. Arithmetic edges:
   - 0xFFFFFFFF+1 → sum_o=0, carry_o=1, ovf_o=0.
   - 0x7FFFFFFF+1 → sum_o=0x80000000, carry_o=0, ovf_o=1.
   - 0x80000000+0x80000000 → sum_o=0, carry_o=1, ovf_o=1.
4. Backpressure: ready_i=0 for 5 cycles after valid_o rises, with req_i=0110 pending → valid_o, sum_o and id_o stay stable and no gnt_o is issued. After ready_i=1: next grant goes to requester 1 if ptr=1, otherwise per round-robin.
5. Wrap-around: the last winner is requester 3, then req_i=1001 → requester 0 wins (ptr=0), not requester 3.
6. Reset mid-operation: assert rst_i for one cycle during CALC → next cycle valid_o=0, gnt_o=0, ptr=0. A held req_i=0100 is then granted (gnt_o=0100) two cycles after rst_i deasserts.
